// File: rtl/fa_seq_ctrl_if.sv
// fa_seq_ctrl_if: request/result bus of the wide-add sequencer.
// Handshake rule (both directions): a word moves on a rising clk edge
// where valid and ready are both high; the valid side holds its payload
// stable until that edge and never waits on ready before raising valid.
interface fa_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // request side
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;

    // result side
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    // requester / result consumer
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    // sequencing controller
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/fa_seq_ctrl.sv
// fa_seq_ctrl: performs a W-bit add/subtract by pushing one nibble per clock,
// least significant first, through an external combinational 4-bit adder
// and chaining the carry through carry_r.
// Optional feature: define FA_SEQ_OVF_EN to add the two's-complement
// overflow output `ovf`; without it the port and its logic are absent.
module fa_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    fa_seq_ctrl_if.slave bus,
    output logic       busy,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic       cin4,
    input  logic [3:0] sum4,
    input  logic       cout4,
`ifdef FA_SEQ_OVF_EN
    output logic       ovf,
`endif
    output logic [1:0] dbg_state
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  a_r;         // latched operand a
    logic [W-1:0]  b_r;         // latched operand b, already inverted for sub
    logic [W-1:0]  sum_r;       // partial result being built slice by slice
    logic [W-1:0]  res_r;       // published result, only changes on RUN->DONE
    logic          carry_r;     // carry into the current slice
    logic          cout_r;      // published carry out
    logic [IW-1:0] idx;         // current slice
`ifdef FA_SEQ_OVF_EN
    logic          ovf_r;
`endif

    logic          accept;
    logic          last_slice;
    logic [IW+1:0] base;        // bit offset of the current slice
    logic [W-1:0]  sum_merged;  // sum_r with this cycle's adder nibble inserted

    // Handshake and slice bookkeeping decoded from the current state.
    always_comb begin
        accept     = 1'b0;
        last_slice = 1'b0;
        base       = {idx, 2'b00};
        sum_merged = sum_r;
        if (state == IDLE && bus.in_valid) begin
            accept = 1'b1;
        end
        if (idx == LAST_IDX) begin
            last_slice = 1'b1;
        end
        sum_merged[base +: 4] = sum4;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on acceptance, RUN -> DONE after the last
    // slice, DONE -> IDLE when the result is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs; the adder inputs are held at zero outside RUN so the
    // external adder stays quiet.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        s1            = 4'h0;
        s2            = 4'h0;
        cin4          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
            end
            RUN: begin
                busy = 1'b1;
                s1   = a_r[base +: 4];
                s2   = b_r[base +: 4];
                cin4 = carry_r;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    // Operand capture at acceptance and slice-by-slice accumulation in RUN.
    // Subtraction is a + ~b + 1, so the inversion and the forced carry-in are
    // applied once here and the RUN loop never looks at `sub` again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            sum_r   <= '0;
            idx     <= '0;
        end else if (state == RUN) begin
            sum_r   <= sum_merged;
            carry_r <= cout4;
            idx     <= last_slice ? '0 : idx + 1'b1;
        end
    end

    // Published result: updated only when the final slice lands, so `sum`
    // and `cout` hold steady through IDLE, RUN and DONE backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r  <= '0;
            cout_r <= 1'b0;
        end else if (state == RUN && last_slice) begin
            res_r  <= sum_merged;
            cout_r <= cout4;
        end
    end

`ifdef FA_SEQ_OVF_EN
    // Signed overflow: operands agree in sign but the result does not.
    // b_r is the post-inversion operand, so this also covers subtraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (state == RUN && last_slice) begin
            ovf_r <= (a_r[W-1] == b_r[W-1]) && (sum_merged[W-1] != a_r[W-1]);
        end
    end

    assign ovf = ovf_r;
`endif

    assign bus.sum   = res_r;
    assign bus.cout  = cout_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_fa_seq_ctrl.sv
// tb_fa_seq_ctrl: directed bench for fa_seq_ctrl with a 4-nibble instance
// (main datapath, handshakes, reset) and a 1-nibble instance (single-cycle
// RUN and, when FA_SEQ_OVF_EN is defined, the overflow flag).
module tb_fa_seq_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- 4-nibble instance ----------------
    fa_seq_ctrl_if #(.NIBBLES(4)) bus4 ();
    logic       busy_4;
    logic [3:0] s1_4, s2_4, sum4_4;
    logic       cin4_4, cout4_4;
    logic [1:0] st_4;

    // external 4-bit adder model
    assign {cout4_4, sum4_4} = {1'b0, s1_4} + {1'b0, s2_4} + {4'b0000, cin4_4};

    fa_seq_ctrl #(.NIBBLES(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4),
        .busy      (busy_4),
        .s1        (s1_4),
        .s2        (s2_4),
        .cin4      (cin4_4),
        .sum4      (sum4_4),
        .cout4     (cout4_4),
`ifdef FA_SEQ_OVF_EN
        .ovf       (),
`endif
        .dbg_state (st_4)
    );

    // ---------------- 1-nibble instance ----------------
    fa_seq_ctrl_if #(.NIBBLES(1)) bus1 ();
    logic       busy_1;
    logic [3:0] s1_1, s2_1, sum4_1;
    logic       cin4_1, cout4_1;
    logic [1:0] st_1;
`ifdef FA_SEQ_OVF_EN
    logic       ovf_1;
`endif

    assign {cout4_1, sum4_1} = {1'b0, s1_1} + {1'b0, s2_1} + {4'b0000, cin4_1};

    fa_seq_ctrl #(.NIBBLES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .busy      (busy_1),
        .s1        (s1_1),
        .s2        (s2_1),
        .cin4      (cin4_1),
        .sum4      (sum4_1),
        .cout4     (cout4_1),
`ifdef FA_SEQ_OVF_EN
        .ovf       (ovf_1),
`endif
        .dbg_state (st_1)
    );

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sample/drive point: 1 time unit after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for out_valid on the 4-nibble instance
    task automatic wait_valid4(output int n);
        n = 0;
        while (bus4.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // full operation on the 4-nibble instance with slice-by-slice checks
    task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input logic [15:0] exp_sum,
                       input logic exp_cout);
        logic [15:0] bx;
        int n;
        bx = s ? ~b : b;
        bus4.a         = a;
        bus4.b         = b;
        bus4.cin       = c;
        bus4.sub       = s;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b0;
        check({tag, ":in_ready"}, 32'(bus4.in_ready), 32'd1);
        tick();
        // operands must be ignored after acceptance
        bus4.in_valid = 1'b0;
        bus4.a        = 16'($urandom);
        bus4.b        = 16'($urandom);
        bus4.cin      = 1'($urandom_range(0, 1));
        bus4.sub      = 1'($urandom_range(0, 1));
        check({tag, ":busy"}, 32'(busy_4), 32'd1);
        n = 0;
        while (bus4.out_valid !== 1'b1 && n < 20) begin
            if (n < 4) begin
                check($sformatf("%s:s1[%0d]", tag, n), 32'(s1_4), 32'(a[4*n +: 4]));
                check($sformatf("%s:s2[%0d]", tag, n), 32'(s2_4), 32'(bx[4*n +: 4]));
            end
            tick();
            n++;
        end
        check({tag, ":run_cycles"}, 32'(n), 32'd4);
        check({tag, ":sum"}, 32'(bus4.sum), 32'(exp_sum));
        check({tag, ":cout"}, 32'(bus4.cout), 32'(exp_cout));
        check({tag, ":quiet_s1"}, 32'(s1_4), 32'd0);
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        check({tag, ":back_idle"}, 32'({bus4.in_ready, bus4.out_valid, busy_4}), 32'b100);
    endtask

    // full operation on the 1-nibble instance
    task automatic op1(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic s, input logic [3:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf);
        bus1.a         = a;
        bus1.b         = b;
        bus1.cin       = c;
        bus1.sub       = s;
        bus1.in_valid  = 1'b1;
        bus1.out_ready = 1'b0;
        tick();
        bus1.in_valid = 1'b0;
        bus1.a        = 4'($urandom);
        bus1.b        = 4'($urandom);
        check({tag, ":run_one"}, 32'({busy_1, bus1.out_valid, st_1}), 32'b1001);
        check({tag, ":s1"}, 32'(s1_1), 32'(a));
        tick();
        check({tag, ":out_valid"}, 32'(bus1.out_valid), 32'd1);
        check({tag, ":sum"}, 32'(bus1.sum), 32'(exp_sum));
        check({tag, ":cout"}, 32'(bus1.cout), 32'(exp_cout));
`ifdef FA_SEQ_OVF_EN
        check({tag, ":ovf"}, 32'(ovf_1), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("[TB] unused ovf expectation");
`endif
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check({tag, ":idle"}, 32'(bus1.in_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int seen;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus1.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();

        // reset state
        check("rst:in_ready", 32'(bus4.in_ready), 32'd1);
        check("rst:out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst:busy", 32'(busy_4), 32'd0);
        check("rst:sum", 32'(bus4.sum), 32'd0);
        check("rst:cout", 32'(bus4.cout), 32'd0);
        check("rst:adder_in", 32'({s1_4, s2_4, cin4_4}), 32'd0);
        check("rst:state", 32'(st_4), 32'd0);
        rst_n = 1'b1;
        tick();

        // main datapath
        op4("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        op4("cin1",      16'h8F0F, 16'h70F0, 1'b1, 1'b0, 16'h0000, 1'b1);
        op4("cin0",      16'h8F0F, 16'h70F0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        op4("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        op4("sub_ok",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
        op4("sub_cin_ig",16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        op4("mixed",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);

        // backpressure
        bus4.a = 16'h1234; bus4.b = 16'h4321; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        wait_valid4(n);
        check("bp:latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp:hold_sum[%0d]", i), 32'(bus4.sum), 32'h5555);
            check($sformatf("bp:hold_hs[%0d]", i), 32'({bus4.in_ready, bus4.out_valid}), 32'b01);
            tick();
        end
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        check("bp:idle", 32'({bus4.in_ready, bus4.out_valid}), 32'b10);
        bus4.a = 16'h0007; bus4.b = 16'h0005; bus4.sub = 1'b1; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        check("bp:reaccept", 32'({busy_4, bus4.in_ready, st_4}), 32'b1001);
        wait_valid4(n);
        check("bp:sum2", 32'(bus4.sum), 32'h0002);
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;

        // reset mid-RUN
        bus4.a = 16'hFFFF; bus4.b = 16'h0001; bus4.sub = 1'b0; bus4.cin = 1'b0;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        tick();
        tick();
        check("mid:busy", 32'({busy_4, bus4.out_valid}), 32'b10);
        check("mid:sum_held", 32'(bus4.sum), 32'h0002);
        rst_n = 1'b0;
        #1;
        check("mid:rst_hs", 32'({bus4.out_valid, busy_4, bus4.in_ready}), 32'b001);
        check("mid:rst_sum", 32'(bus4.sum), 32'd0);
        check("mid:rst_adder", 32'({s1_4, s2_4, cin4_4}), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus4.out_valid !== 1'b0) seen++;
        end
        check("mid:no_result", 32'(seen), 32'd0);
        check("mid:in_ready", 32'(bus4.in_ready), 32'd1);

        // single-nibble instance
        op1("n1_7p1", 4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
        op1("n1_Fp8", 4'hF, 4'h8, 1'b0, 1'b0, 4'h7, 1'b1, 1'b1);
        op1("n1_3p2", 4'h3, 4'h2, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
        op1("n1_3m5", 4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
